// File: rtl/prec_carry_pkg.sv
// Shared types and segment-geometry helpers for the segmented carry pipe.
package prec_carry_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned LANE_MIN_DEF = 2;
    localparam int unsigned MODE_W_DEF   = 3;
    localparam int unsigned NCHUNK       = DATA_W_DEF / LANE_MIN_DEF;

    typedef logic [1:0] cnt2_t;
    typedef int unsigned uint_t;

    // Comparing chunk counts rather than bit widths keeps the shift from wrapping.
    function automatic logic mode_legal(uint_t mode, uint_t lane_min, uint_t data_w);
        if (mode >= 31) begin
            return 1'b0;
        end
        return (uint_t'(1) << mode) <= (data_w / lane_min);
    endfunction

    function automatic uint_t chunks_per_seg(uint_t mode, uint_t lane_min, uint_t data_w);
        return mode_legal(mode, lane_min, data_w) ? (uint_t'(1) << mode) : (data_w / lane_min);
    endfunction

    function automatic uint_t seg_w(uint_t mode, uint_t lane_min, uint_t data_w);
        return chunks_per_seg(mode, lane_min, data_w) * lane_min;
    endfunction

    function automatic logic is_seg_start(uint_t chunk, uint_t mode, uint_t lane_min,
                                          uint_t data_w);
        return (chunk & (chunks_per_seg(mode, lane_min, data_w) - 1)) == 0;
    endfunction

    function automatic logic is_seg_top(uint_t chunk, uint_t mode, uint_t lane_min,
                                        uint_t data_w);
        return ((chunk + 1) & (chunks_per_seg(mode, lane_min, data_w) - 1)) == 0;
    endfunction

endpackage

// File: rtl/prec_carry_pipe_chunk.sv
// One chunk of the carry ripple: raw pair sum plus incoming carry count.
module prec_chunk_add
    import prec_carry_pkg::*;
#(
    parameter int unsigned LANE_MIN = 2
) (
    input  logic [LANE_MIN:0]   i_p,
    input  cnt2_t               i_cin,
    output logic [LANE_MIN-1:0] o_sum,
    output cnt2_t               o_carry
);

    // p <= 2^(L+1)-2 and cin <= 2, so the total always fits in L+2 bits.
    logic [LANE_MIN+1:0] w_t;

    assign w_t     = {1'b0, i_p} + {{LANE_MIN{1'b0}}, i_cin};
    assign o_sum   = w_t[LANE_MIN-1:0];
    assign o_carry = w_t[LANE_MIN+1:LANE_MIN];

endmodule

// File: rtl/prec_carry_pipe.sv
// Two-stage segmented adder: per segment w' + x' + a + b with 2-bit carry counts.
// Optional signed-overflow flags are built when PREC_CARRY_OVF_EN is defined.
module prec_carry_pipe
    import prec_carry_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LANE_MIN = 2,
    parameter int unsigned MODE_W   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [DATA_W-1:0]                i_w,
    input  logic [DATA_W-1:0]                i_x,
    input  logic                             i_a,
    input  logic                             i_b,
    input  logic [MODE_W-1:0]                i_mode,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic [DATA_W-1:0]                o_sum,
    output logic [2*(DATA_W/LANE_MIN)-1:0]   o_cout,
`ifdef PREC_CARRY_OVF_EN
    output logic [DATA_W/LANE_MIN-1:0]       o_ovf,
`endif
    output logic                             o_mode_err
);

    localparam int unsigned N_CH = DATA_W / LANE_MIN;
    localparam int unsigned PW   = LANE_MIN + 1;

    logic                      w_s2_load;
    logic                      w_in_ready;
    logic [DATA_W-1:0]         w_wp;
    logic [DATA_W-1:0]         w_xp;
    cnt2_t                     w_ab;
    logic [N_CH-1:0][PW-1:0]   w_p;

    logic                      r_s1_valid;
    cnt2_t                     r_ab;
    logic [MODE_W-1:0]         r_mode;
    logic [N_CH-1:0][PW-1:0]   r_p;

    logic [DATA_W-1:0]         w_sum;
    logic [2*N_CH-1:0]         w_cout;
    logic                      w_mode_err;

    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_sum;
    logic [2*N_CH-1:0]         r_cout;
    logic                      r_mode_err;

`ifdef PREC_CARRY_OVF_EN
    logic [N_CH-1:0]           w_wp_msb;
    logic [N_CH-1:0]           w_xp_msb;
    logic [N_CH-1:0]           r_wp_msb;
    logic [N_CH-1:0]           r_xp_msb;
    logic [N_CH-1:0]           w_ovf;
    logic [N_CH-1:0]           r_ovf;
`endif

    // Handshake: no skid buffer, so ready is combinational from downstream.
    assign w_s2_load  = !r_out_valid || i_out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;

    assign w_wp = i_b ? ~i_w : i_w;
    assign w_xp = i_a ? ~i_x : i_x;
    assign w_ab = {1'b0, i_a} + {1'b0, i_b};

    for (genvar k = 0; k < N_CH; k++) begin : g_raw
        assign w_p[k] = {1'b0, w_wp[k*LANE_MIN +: LANE_MIN]}
                      + {1'b0, w_xp[k*LANE_MIN +: LANE_MIN]};
`ifdef PREC_CARRY_OVF_EN
        assign w_wp_msb[k] = w_wp[k*LANE_MIN + LANE_MIN - 1];
        assign w_xp_msb[k] = w_xp[k*LANE_MIN + LANE_MIN - 1];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_ab       <= '0;
            r_mode     <= '0;
            r_p        <= '0;
`ifdef PREC_CARRY_OVF_EN
            r_wp_msb   <= '0;
            r_xp_msb   <= '0;
`endif
        end else if (w_in_ready) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_ab     <= w_ab;
                r_mode   <= i_mode;
                r_p      <= w_p;
`ifdef PREC_CARRY_OVF_EN
                r_wp_msb <= w_wp_msb;
                r_xp_msb <= w_xp_msb;
`endif
            end
        end
    end

    // Illegal modes fall back to a single full-width segment inside the helpers.
    assign w_mode_err = !mode_legal(uint_t'(r_mode), LANE_MIN, DATA_W);

    for (genvar k = 0; k < N_CH; k++) begin : g_chunk
        cnt2_t               w_cin;
        cnt2_t               w_carry;
        logic [LANE_MIN-1:0] w_sum_k;
        logic                w_top;

        if (k == 0) begin : g_first
            assign w_cin = r_ab;
        end else begin : g_rest
            assign w_cin = is_seg_start(uint_t'(k), uint_t'(r_mode), LANE_MIN, DATA_W)
                         ? r_ab : g_chunk[k-1].w_carry;
        end

        assign w_top = is_seg_top(uint_t'(k), uint_t'(r_mode), LANE_MIN, DATA_W);

        prec_chunk_add #(
            .LANE_MIN (LANE_MIN)
        ) u_add (
            .i_p     (r_p[k]),
            .i_cin   (w_cin),
            .o_sum   (w_sum_k),
            .o_carry (w_carry)
        );

        assign w_sum[k*LANE_MIN +: LANE_MIN] = w_sum_k;
        assign w_cout[2*k +: 2]              = w_top ? w_carry : 2'b00;

`ifdef PREC_CARRY_OVF_EN
        // Signed overflow iff carry + result sign differs from the operand sign sum.
        logic [2:0] w_lhs;
        logic [2:0] w_rhs;
        assign w_lhs    = {1'b0, w_carry} + {2'b00, w_sum_k[LANE_MIN-1]};
        assign w_rhs    = {2'b00, r_wp_msb[k]} + {2'b00, r_xp_msb[k]};
        assign w_ovf[k] = w_top && (w_lhs != w_rhs);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= '0;
            r_mode_err  <= 1'b0;
`ifdef PREC_CARRY_OVF_EN
            r_ovf       <= '0;
`endif
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum      <= w_sum;
                r_cout     <= w_cout;
                r_mode_err <= w_mode_err;
`ifdef PREC_CARRY_OVF_EN
                r_ovf      <= w_ovf;
`endif
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_mode_err  = r_mode_err;
`ifdef PREC_CARRY_OVF_EN
    assign o_ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_prec_carry_pipe.sv
// Directed + scoreboard bench for prec_carry_pipe (DATA_W=16, LANE_MIN=2).
module tb_prec_carry_pipe;

    typedef struct packed {
        logic [15:0] sum;
        logic [15:0] cout;
        logic        err;
        logic [7:0]  ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_w;
    logic [15:0] i_x;
    logic        i_a;
    logic        i_b;
    logic [2:0]  i_mode;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [15:0] o_sum;
    logic [15:0] o_cout;
    logic        o_mode_err;
`ifdef PREC_CARRY_OVF_EN
    logic [7:0]  o_ovf;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    prec_carry_pipe #(
        .DATA_W   (16),
        .LANE_MIN (2),
        .MODE_W   (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_w         (i_w),
        .i_x         (i_x),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_mode      (i_mode),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
`ifdef PREC_CARRY_OVF_EN
        .o_ovf       (o_ovf),
`endif
        .o_mode_err  (o_mode_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Segment-level reference, independent of the chunk ripple.
    function automatic exp_t model(input logic [15:0] w, input logic [15:0] x,
                                   input logic a, input logic b, input logic [2:0] mode);
        exp_t        e;
        logic [15:0] wp;
        logic [15:0] xp;
        longint      n, ab, msk, ws, xs, tot, sm, half, sws, sxs, sres, top;
        e   = '0;
        wp  = b ? ~w : w;
        xp  = a ? ~x : x;
        ab  = longint'(a) + longint'(b);
        e.err = (mode > 3);
        n   = e.err ? 16 : (longint'(2) << mode);
        msk = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        for (int base = 0; base < 16; base += int'(n)) begin
            ws  = longint'(wp >> base) & msk;
            xs  = longint'(xp >> base) & msk;
            tot = ws + xs + ab;
            sm  = tot & msk;
            e.sum = e.sum | 16'(sm << base);
            top = (base + n) / 2 - 1;
            e.cout[2*top +: 2] = 2'(tot >> n);
            sws  = (ws >= half) ? ws - (msk + 1) : ws;
            sxs  = (xs >= half) ? xs - (msk + 1) : xs;
            sres = (sm >= half) ? sm - (msk + 1) : sm;
            e.ovf[top] = ((sws + sxs + ab) != sres);
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic [15:0] c, input logic err,
                                input logic [7:0] ovf);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.err  = err;
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic [15:0] x, input logic a,
                        input logic b, input logic [2:0] mode, input exp_t e);
        bit ok;
        ok = 1'b0;
        i_in_valid = 1'b1;
        i_w = w;
        i_x = x;
        i_a = a;
        i_b = b;
        i_mode = mode;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (o_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $error("FAIL accept_timeout: observed=not_ready expected=ready");
        end else begin
            sb.push_back(e);
        end
        step();
        i_in_valid = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks hold stability.
    exp_t        m_e;
    logic        m_held = 1'b0;
    logic [15:0] m_sum;
    logic [15:0] m_cout;
    logic        m_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_held = 1'b0;
        end else if (o_out_valid) begin
            if (m_held) begin
                chk("hold_sum", 32'(o_sum), 32'(m_sum));
                chk("hold_cout", 32'(o_cout), 32'(m_cout));
                chk("hold_err", 32'(o_mode_err), 32'(m_err));
            end
            if (i_out_ready) begin
                m_held = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(o_out_valid), 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("sum", 32'(o_sum), 32'(m_e.sum));
                    chk("cout", 32'(o_cout), 32'(m_e.cout));
                    chk("mode_err", 32'(o_mode_err), 32'(m_e.err));
`ifdef PREC_CARRY_OVF_EN
                    chk("ovf", 32'(o_ovf), 32'(m_e.ovf));
`endif
                end
            end else begin
                m_held = 1'b1;
                m_sum  = o_sum;
                m_cout = o_cout;
                m_err  = o_mode_err;
            end
        end
    end

    initial begin
        logic [15:0] rw;
        logic [15:0] rx;
        logic        ra;
        logic        rb;
        logic [2:0]  rm;
        rst_n = 1'b0;
        i_in_valid = 1'b0;
        i_w = '0;
        i_x = '0;
        i_a = 1'b0;
        i_b = 1'b0;
        i_mode = '0;
        i_out_ready = 1'b1;
        #23;
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);
        chk("rst_cout", 32'(o_cout), 32'd0);
        chk("rst_mode_err", 32'(o_mode_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);

        // Test 1 with explicit two-edge latency.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 3'd3, mk(16'h0100, 16'h0000, 1'b0, 8'h00));
        @(negedge clk);
        chk("lat_edge1", 32'(o_out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("lat_edge2", 32'(o_out_valid), 32'd1);
        step();

        send(16'h0000, 16'h0000, 1'b1, 1'b1, 3'd2, mk(16'h0000, 16'h8080, 1'b0, 8'h00));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'd0, mk(16'hFFFC, 16'h0001, 1'b0, 8'h00));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'd5, mk(16'h8000, 16'h0000, 1'b1, 8'h80));
        repeat (4) step();

        // Test 4: stall with two beats held, then release.
        i_out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b1, 3'd1, model(16'h1234, 16'h4321, 1'b0, 1'b1, 3'd1));
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 3'd3, model(16'hAAAA, 16'h5555, 1'b1, 1'b0, 3'd3));
        i_in_valid = 1'b1;
        i_w = 16'hF0F0;
        i_x = 16'h0F0F;
        i_a = 1'b1;
        i_b = 1'b1;
        i_mode = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(o_in_ready), 32'd0);
            chk("stall_out_valid", 32'(o_out_valid), 32'd1);
            step();
        end
        i_out_ready = 1'b1;
        send(16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 3'd2, model(16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 3'd2));
        @(negedge clk);
        chk("drain_gap1", 32'(o_out_valid), 32'd1);
        step();
        @(negedge clk);
        chk("drain_gap2", 32'(o_out_valid), 32'd1);
        step();

        // Mixed-mode random beats against the model.
        for (int i = 0; i < 24; i++) begin
            rw = 16'($urandom);
            rx = 16'($urandom);
            ra = 1'($urandom);
            rb = 1'($urandom);
            rm = 3'($urandom_range(0, 7));
            send(rw, rx, ra, rb, rm, model(rw, rx, ra, rb, rm));
            if ($urandom_range(0, 3) == 0) step();
        end
        for (int t = 0; t < 20 && sb.size() != 0; t++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        // Test 6: reset mid-stream discards the held beat.
        i_out_ready = 1'b0;
        send(16'h1234, 16'h0101, 1'b0, 1'b0, 3'd3, model(16'h1234, 16'h0101, 1'b0, 1'b0, 3'd3));
        for (int t = 0; t < 10 && !o_out_valid; t++) step();
        chk("pre_rst_valid", 32'(o_out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(o_out_valid), 32'd0);
        chk("async_sum", 32'(o_sum), 32'd0);
        chk("async_cout", 32'(o_cout), 32'd0);
        sb.delete();
        repeat (2) step();
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(o_out_valid), 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
